io_switch_port: RTL
===================

Name: io_switch_port

Overview:
- Registered, parametrised output-port cell for the 16x16 switch fabric.
- Selects one of N_IN input lanes, each DATA_W bits wide, using a reflected-Gray-coded select.
- Select and enable are loaded through a valid/ready config handshake.
- Enforces a break-before-make guard interval when switching source, so two drivers never appear back-to-back on the pad.

Parameters:
- N_IN, 16, number of input lanes; legal range 2..64.
- DATA_W, 1, width of each lane and of the output in bits.
- GUARD, 2, number of cycles the output is held disabled between an accepted reconfig and re-enable; must be >= 1.
- SEL_W (localparam), clog2(N_IN), width of the select code.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in  in  N_IN*DATA_W  input lanes; lane i occupies bits [i*DATA_W +: DATA_W].
- cfg_sel  in  SEL_W  Gray-coded source select.
- cfg_oe  in  1  requested output enable.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config can be accepted this cycle.
- sel_err  out  1  one-cycle pulse: the accepted code decoded to an index >= N_IN.
- busy  out  1  high while in BREAK.
- out_en  out  1  registered output enable.
- out  out  DATA_W  equals data_q when out_en=1, else all bits 'z'.

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high.
  - While rst is high: state=OFF, act_idx=0, act_oe=0, data_q=0, out_en=0, sel_err=0, busy=0, cfg_ready=0.
  - rst overrides everything, including mid-BREAK: the guard is aborted and the block goes to OFF.
- Decode: idx = gray2bin(cfg_sel), where b[MSB]=g[MSB] and b[k]=b[k+1]^g[k].
  - With N_IN=16 this gives 0000->0, 0001->1, 0011->2, 0010->3, ... 1000->15.
- Handshake:
  - Transfer occurs when cfg_valid && cfg_ready at a clock edge.
  - cfg_ready = !rst && state!=BREAK (combinational from state).
  - cfg_valid held during BREAK is not consumed; the request stays pending until ready.
- Invalid code (idx >= N_IN; only possible when N_IN is not a power of 2):
  - The transfer completes (ready honoured).
  - act_idx, act_oe and state are unchanged.
  - sel_err=1 for exactly the next cycle.
- Datapath:
  - data_q <= lane[act_idx] on every edge, in every state.
  - Lane-to-out latency is 1 cycle when out_en=1.
  - data_q already tracks the new lane during BREAK, so the first enabled cycle carries valid data.
- States:
  - OFF: out_en=0.
    - Valid cfg with oe=0: latch act_idx and stay OFF.
    - Valid cfg with oe=1: latch act_idx, set cnt=GUARD-1, go to BREAK.
  - BREAK: out_en=0, busy=1.
    - If cnt==0, go to ON; otherwise decrement cnt.
    - Exactly GUARD cycles are spent in BREAK.
  - ON: out_en=1.
    - Valid cfg with oe=0: go to OFF (out_en=0 from the next cycle; no guard interval).
    - Valid cfg with oe=1 and idx==act_idx: no-op; stay ON with no gap.
    - Valid cfg with oe=1 and a different idx: latch act_idx, set cnt=GUARD-1, go to BREAK.
- out_en is registered as (next_state==ON). It falls on the edge that accepts a source change and rises on the edge leaving BREAK.
- sel_err and valid-code handling are mutually exclusive, since only one config is accepted per cycle.

Test Plan:
1. Reset: assert rst for 3 cycles with cfg_valid=1 -> cfg_ready=0, out_en=0, out=z, busy=0, sel_err=0. After release, cfg_ready=1.
2. From OFF, drive cfg_sel=4'b0011, cfg_oe=1, accepted at edge k (N_IN=16, DATA_W=1, GUARD=2, in[2]=1) -> busy=1 and out_en=0 for 2 cycles; out_en=1 from edge k+2; out=1. Toggling in[2] is seen on out 1 cycle later.
3. While ON with lane 2, accept cfg_sel=4'b1000, oe=1 (in[15]=0, in[2]=1) -> out=z for exactly 2 cycles, then out=0. The old lane value is never driven after the accept edge.
4. While ON with lane 15, re-send cfg_sel=4'b1000, oe=1 -> no BREAK; out_en stays 1 continuously. Then send oe=0 -> out=z the next cycle with busy=0.
5. N_IN=12: accept cfg_sel=4'b1010 (idx 12) while ON with lane 5 -> sel_err=1 for one cycle; out still follows in[5]; out_en stays 1.
6. Hold cfg_valid during BREAK with a new code -> cfg_ready=0 and the request is not taken; it is accepted on the first ON cycle, which starts a fresh BREAK. Asserting rst mid-BREAK -> OFF next cycle with out_en=0 and act_idx=0.

Source files
------------

// File: rtl/io_switch_port.sv
// Registered switch-fabric output port: Gray-coded lane select, valid/ready config,
// and a break-before-make guard so two sources never drive the pad back-to-back.
//  state | meaning
//  OFF   | output disabled, config accepted
//  BREAK | guard interval after a source change, config stalled
//  ON    | output driven from the active lane
module io_switch_port #(
    parameter int N_IN   = 16,
    parameter int DATA_W = 1,
    parameter int GUARD  = 2,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_IN*DATA_W-1:0] in,
    input  logic [SEL_W-1:0]       cfg_sel,
    input  logic                   cfg_oe,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    output logic                   sel_err,
    output logic                   busy,
    output logic                   out_en,
    output logic [DATA_W-1:0]      out
);
    localparam int CNT_W = (GUARD > 1) ? $clog2(GUARD) : 1;

    typedef enum logic [1:0] {OFF, BREAK, ON} state_t;

    state_t            state, state_n;
    logic [SEL_W-1:0]  act_idx, idx;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] lanes [N_IN];
    logic              accept, code_ok, load_idx;

    for (genvar i = 0; i < N_IN; i++) begin : g_lane
        assign lanes[i] = in[i*DATA_W +: DATA_W];
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        idx = '0;
        for (int k = 0; k < SEL_W; k++) idx[k] = ^(cfg_sel >> k);
    end

    assign code_ok = (int'(idx) < N_IN);
    assign accept  = cfg_valid && cfg_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= OFF;
            act_idx <= '0;
            cnt     <= '0;
            data_q  <= '0;
            out_en  <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            state   <= state_n;
            data_q  <= lanes[act_idx];
            out_en  <= (state_n == ON);
            sel_err <= accept && !code_ok;
            if (load_idx) act_idx <= idx;
            if (state_n == BREAK && state != BREAK) cnt <= CNT_W'(GUARD - 1);
            else if (state == BREAK && cnt != '0) cnt <= cnt - CNT_W'(1);
        end
    end

    always_comb begin
        state_n  = state;
        load_idx = 1'b0;
        case (state)
            OFF: begin
                if (accept && code_ok) begin
                    load_idx = 1'b1;
                    if (cfg_oe) state_n = BREAK;
                end
            end
            BREAK: begin
                if (cnt == '0) state_n = ON;
            end
            ON: begin
                if (accept && code_ok) begin
                    if (!cfg_oe) begin
                        state_n = OFF;
                    end else if (idx != act_idx) begin
                        load_idx = 1'b1;
                        state_n  = BREAK;
                    end
                end
            end
            default: state_n = OFF;
        endcase
    end

    always_comb begin
        busy      = (state == BREAK);
        cfg_ready = !rst && (state != BREAK);
    end

    assign out = out_en ? data_q : {DATA_W{1'bz}};

endmodule
